// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - multi-channel button synchronizer, debouncer and press/long/repeat event generator
//
// Ports:
//   clk          system clock, all state on the rising edge
//   reset        synchronous active-high reset
//   i_btn        raw asynchronous button levels, 1 = pressed
//   i_repeat_en  per-channel auto-repeat enable (synchronous to clk)
//   o_level      debounced button level
//   o_press      one-cycle pulse in the first cycle o_level is 1
//   o_release    one-cycle pulse in the first cycle o_level is 0 after being 1
//   o_long       one-cycle pulse when the button has been held LP_CYCLES
//   o_repeat     one-cycle auto-repeat pulses every RP_CYCLES after the long press
module btn_conditioner #(
    parameter int NUM_BTN          = 4,
    parameter int CLK_FREQ_HZ      = 100_000_000,
    parameter int DEBOUNCE_TIME_MS = 20,
    parameter int LONG_PRESS_MS    = 1000,
    parameter int REPEAT_MS        = 200
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] i_btn,
    input  logic [NUM_BTN-1:0] i_repeat_en,
    output logic [NUM_BTN-1:0] o_level,
    output logic [NUM_BTN-1:0] o_press,
    output logic [NUM_BTN-1:0] o_release,
    output logic [NUM_BTN-1:0] o_long,
    output logic [NUM_BTN-1:0] o_repeat
);

    localparam int CLK_MS    = CLK_FREQ_HZ / 1000;
    localparam int DB_CYCLES = DEBOUNCE_TIME_MS * CLK_MS;
    localparam int LP_CYCLES = LONG_PRESS_MS * CLK_MS;
    localparam int RP_CYCLES = REPEAT_MS * CLK_MS;

    localparam bit LP_EN = (LP_CYCLES > 0);

    localparam int DBW = $clog2(DB_CYCLES + 1);
    localparam int HCW = (LP_CYCLES > 0) ? $clog2(LP_CYCLES + 1) : 1;
    localparam int RPW = (RP_CYCLES > 0) ? $clog2(RP_CYCLES + 1) : 1;

    // Counters stop one short of the target: the event is registered on the
    // edge where the count would have reached it, so the output lands exactly
    // in the target cycle.
    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);
    localparam logic [HCW-1:0] HC_LAST = HCW'((LP_CYCLES > 0) ? LP_CYCLES - 1 : 0);
    localparam logic [RPW-1:0] RP_LAST = RPW'((RP_CYCLES > 0) ? RP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HELD = 2'd1,
        LONG = 2'd2
    } hold_state_t;

    for (genvar g = 0; g < NUM_BTN; g++) begin : gen_ch
        logic           sync1, sync2;
        logic           level_q, press_q, release_q, long_q, repeat_q;
        logic [DBW-1:0] db_cnt, db_cnt_n;
        logic [HCW-1:0] hold_cnt, hold_cnt_n;
        logic [RPW-1:0] rep_cnt, rep_cnt_n;
        hold_state_t    state, state_n;
        logic           level_n, rise, fall, long_n, repeat_n;

        always_comb begin
            db_cnt_n   = '0;
            level_n    = level_q;
            rise       = 1'b0;
            fall       = 1'b0;
            state_n    = state;
            hold_cnt_n = hold_cnt;
            rep_cnt_n  = rep_cnt;
            long_n     = 1'b0;
            repeat_n   = 1'b0;

            if (sync2 != level_q) begin
                if (db_cnt == DB_LAST) begin
                    level_n = ~level_q;
                    rise    = ~level_q;
                    fall    = level_q;
                end else begin
                    db_cnt_n = db_cnt + 1'b1;
                end
            end

            // fall is tested first so a release always wins over long/repeat
            unique case (state)
                IDLE: begin
                    if (rise) begin
                        state_n    = HELD;
                        hold_cnt_n = '0;
                    end
                end
                HELD: begin
                    if (fall) begin
                        state_n = IDLE;
                    end else if (LP_EN) begin
                        if (hold_cnt == HC_LAST) begin
                            state_n   = LONG;
                            long_n    = 1'b1;
                            rep_cnt_n = '0;
                        end else begin
                            hold_cnt_n = hold_cnt + 1'b1;
                        end
                    end
                end
                LONG: begin
                    if (fall) begin
                        state_n = IDLE;
                    end else if (!i_repeat_en[g]) begin
                        rep_cnt_n = '0;
                    end else if (rep_cnt == RP_LAST) begin
                        repeat_n  = 1'b1;
                        rep_cnt_n = '0;
                    end else begin
                        rep_cnt_n = rep_cnt + 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                sync1     <= 1'b0;
                sync2     <= 1'b0;
                db_cnt    <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
                repeat_q  <= 1'b0;
                state     <= IDLE;
                hold_cnt  <= '0;
                rep_cnt   <= '0;
            end else begin
                sync1     <= i_btn[g];
                sync2     <= sync1;
                db_cnt    <= db_cnt_n;
                level_q   <= level_n;
                press_q   <= rise;
                release_q <= fall;
                long_q    <= long_n;
                repeat_q  <= repeat_n;
                state     <= state_n;
                hold_cnt  <= hold_cnt_n;
                rep_cnt   <= rep_cnt_n;
            end
        end

        assign o_level[g]   = level_q;
        assign o_press[g]   = press_q;
        assign o_release[g] = release_q;
        assign o_long[g]    = long_q;
        assign o_repeat[g]  = repeat_q;
    end

endmodule
